// File: rtl/chs_config_receiver.sv
// chs_config_receiver
// Serial-to-parallel receive stage for the cool/heat configuration word.
// Takes 8 data bits MSB first, then one even-parity bit. A frame that passes
// parity becomes the active configuration, together with its ones count and
// parity flag. A bad parity bit or an idle timeout pulses frame_err, and the
// committed outputs keep their old values.
//
// Input qualification: bit_in is only looked at in a cycle where bit_valid=1.
// There is no back-pressure, so every qualified bit in RECV/PARITY is consumed.
// The only exception is a cycle where start is also high: start wins and that
// bit is dropped.
module chs_config_receiver #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       busy,
   output logic [7:0] conf_out,
   output logic       conf_valid,
   output logic       frame_err,
   output logic [3:0] ones_count,
   output logic       parity_even,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   // Last idle-count value before the frame is dropped.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] conf_q, conf_d;
   logic [3:0] ones_q, ones_d;
   logic       par_q, par_d;
   logic       cv_q, cv_d;
   logic       fe_q, fe_d;
   logic       busy_q, busy_d;
   logic [3:0] pop;

   // Ones count of the shift register. It is only registered on a commit.
   always_comb begin
      pop = 4'd0;
      for (int i = 0; i < 8; i++) begin
         pop = pop + {3'd0, shreg_q[i]};
      end
   end

   // Next-state logic: start/abort, bit shifting, parity check, idle timeout.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      conf_d  = conf_q;
      ones_d  = ones_q;
      par_d   = par_q;
      cv_d    = 1'b0;
      fe_d    = 1'b0;

      if (start) begin
         // A start in any state opens a fresh frame. An open frame is dropped
         // without reporting an error.
         state_d = ST_RECV;
         shreg_d = 8'h00;
         idx_d   = 3'd0;
         cnt_d   = 8'h00;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = 8'h00;
            end
            ST_RECV: begin
               if (bit_valid) begin
                  shreg_d = {shreg_q[6:0], bit_in};
                  cnt_d   = 8'h00;
                  if (idx_q == 3'd7) begin
                     idx_d   = 3'd0;
                     state_d = ST_PARITY;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  fe_d    = 1'b1;
                  cnt_d   = 8'h00;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_PARITY: begin
               if (bit_valid) begin
                  cnt_d   = 8'h00;
                  state_d = ST_IDLE;
                  if (bit_in == ^shreg_q) begin
                     conf_d = shreg_q;
                     ones_d = pop;
                     par_d  = ~pop[0];
                     cv_d   = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  fe_d    = 1'b1;
                  cnt_d   = 8'h00;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers. Reset clears them asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= 8'h00;
         idx_q   <= 3'd0;
         cnt_q   <= 8'h00;
         conf_q  <= 8'h00;
         ones_q  <= 4'd0;
         par_q   <= 1'b1;
         cv_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         conf_q  <= conf_d;
         ones_q  <= ones_d;
         par_q   <= par_d;
         cv_q    <= cv_d;
         fe_q    <= fe_d;
         busy_q  <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign conf_out    = conf_q;
   assign conf_valid  = cv_q;
   assign frame_err   = fe_q;
   assign ones_count  = ones_q;
   assign parity_even = par_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_chs_config_receiver.sv
// Bench for chs_config_receiver. Directed frames push the response they
// should produce into exp_q. A monitor on the falling edge pops one entry
// per conf_valid/frame_err pulse and compares every output field.
// Entry layout: {is_err, conf[7:0], ones[3:0], parity_even}.
module tb_chs_config_receiver;

   logic       clk;
   logic       reset;
   logic       start;
   logic       bit_in;
   logic       bit_valid;
   logic       busy;
   logic [7:0] conf_out;
   logic       conf_valid;
   logic       frame_err;
   logic [3:0] ones_count;
   logic       parity_even;
   logic [1:0] dbg_state;

   logic [13:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   chs_config_receiver #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .conf_out   (conf_out),
      .conf_valid (conf_valid),
      .frame_err  (frame_err),
      .ones_count (ones_count),
      .parity_even(parity_even),
      .dbg_state  (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Driver tasks. Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_data(input logic [7:0] d, input int n, input int gap);
      for (int i = 7; i > 7 - n; i--) send_bit(d[i], gap);
   endtask

   task automatic push_ok(input logic [7:0] c, input logic [3:0] o, input logic p);
      exp_q.push_back({1'b0, c, o, p});
   endtask

   task automatic push_err(input logic [7:0] c, input logic [3:0] o, input logic p);
      exp_q.push_back({1'b1, c, o, p});
   endtask

   // Scoreboard monitor.
   initial begin
      logic [13:0] e;
      forever begin
         @(negedge clk);
         if (!reset && (conf_valid || frame_err)) begin
            check("pulse_exclusive", {31'd0, conf_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {30'd0, conf_valid, frame_err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_frame_err", {31'd0, frame_err}, {31'd0, e[13]});
               check("sb_conf_valid", {31'd0, conf_valid}, {31'd0, ~e[13]});
               check("sb_conf_out", {24'd0, conf_out}, {24'd0, e[12:5]});
               check("sb_ones_count", {28'd0, ones_count}, {28'd0, e[4:1]});
               check("sb_parity_even", {31'd0, parity_even}, {31'd0, e[0]});
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_conf_out", {24'd0, conf_out}, 32'd0);
      check("rst_ones_count", {28'd0, ones_count}, 32'd0);
      check("rst_parity_even", {31'd0, parity_even}, 32'd1);
      check("rst_pulses", {30'd0, conf_valid, frame_err}, 32'd0);
      reset = 1'b0;
      tick();

      // bit_valid in IDLE must be ignored.
      send_bit(1'b1, 2);
      check("idle_ignore_busy", {31'd0, busy}, 32'd0);

      // Frame A5 with parity 0, back to back. The pulse comes 10 cycles after
      // the start cycle.
      push_ok(8'hA5, 4'd4, 1'b1);
      send_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      send_data(8'hA5, 8, 0);
      send_bit(1'b0, 0);
      check("a5_latency", {31'd0, conf_valid}, 32'd1);
      check("a5_busy_low", {31'd0, busy}, 32'd0);
      tick();

      // Frame 07 with wrong parity 0.
      push_err(8'hA5, 4'd4, 1'b1);
      send_start();
      send_data(8'h07, 8, 0);
      send_bit(1'b0, 0);
      check("07_frame_err", {31'd0, frame_err}, 32'd1);
      tick();

      // Frame FF with 3 idle cycles after every bit.
      push_ok(8'hFF, 4'd8, 1'b1);
      send_start();
      send_data(8'hFF, 8, 3);
      send_bit(1'b0, 0);
      check("ff_commit", {31'd0, conf_valid}, 32'd1);
      tick();

      // Timeout: 4 bits, then idle. Still busy after 15 idle cycles, error
      // after the 16th.
      push_err(8'hFF, 4'd8, 1'b1);
      send_start();
      send_data(8'h5A, 4, 0);
      repeat (15) tick();
      check("to_busy_before", {31'd0, busy}, 32'd1);
      tick();
      check("to_frame_err", {31'd0, frame_err}, 32'd1);
      check("to_busy_after", {31'd0, busy}, 32'd0);
      tick();

      // Abort: 5 bits, start together with bit_valid, then full frame 3C.
      push_ok(8'h3C, 4'd4, 1'b1);
      send_start();
      send_data(8'hF0, 5, 0);
      start     = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd1);
      check("abort_no_err", {31'd0, frame_err}, 32'd0);
      send_data(8'h3C, 8, 0);
      send_bit(1'b0, 0);
      check("3c_commit", {31'd0, conf_valid}, 32'd1);

      // Back to back: start in the same cycle conf_valid is high.
      push_ok(8'h81, 4'd2, 1'b1);
      send_start();
      send_data(8'h81, 8, 0);
      send_bit(1'b0, 0);
      check("81_commit", {31'd0, conf_valid}, 32'd1);
      tick();

      // Asynchronous reset mid-frame, checked before the next clock edge.
      send_start();
      send_data(8'hC3, 6, 0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_conf_out", {24'd0, conf_out}, 32'd0);
      check("arst_ones_count", {28'd0, ones_count}, 32'd0);
      check("arst_parity_even", {31'd0, parity_even}, 32'd1);
      check("arst_pulses", {30'd0, conf_valid, frame_err}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Frame 01 with parity 1.
      push_ok(8'h01, 4'd1, 1'b0);
      send_start();
      send_data(8'h01, 8, 0);
      send_bit(1'b1, 0);
      check("01_commit", {31'd0, conf_valid}, 32'd1);
      repeat (4) tick();

      check("sb_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
